sparse_neuron_accumulator: RTL and testbench
============================================

SPARSE_NEURON_ACCUMULATOR -- requirements
Module: sparse_neuron_accumulator

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 Parameter INDEX_WIDTH, default 10: width of the pixel index.
REQ-003 Parameter WEIGHT_WIDTH, default 8: width of the signed weight.
REQ-004 Parameter ACC_WIDTH, default 20: width of the signed accumulator, bias and result.
REQ-005 Port clk, input, 1: clock; all state updates on the rising edge.
REQ-006 Port reset, input, 1: synchronous active-high reset.
REQ-007 Port start, input, 1: one-cycle pulse that begins a neuron evaluation.
REQ-008 Port bias, input, ACC_WIDTH: signed initial accumulator value, sampled on an accepted start.
REQ-009 Port indexIn, input, INDEX_WIDTH: head index of the upstream set-pixel queue.
REQ-010 Port queueEmpty, input, 1: upstream queue holds no indices.
REQ-011 Port dequeue, output, 1: one-cycle pulse that pops the upstream queue head.
REQ-012 Port weightAddr, output, INDEX_WIDTH: registered weight-memory address.
REQ-013 Port weightData, input, WEIGHT_WIDTH: signed weight, valid one cycle after weightAddr updates (synchronous ROM).
REQ-014 Port busy, output, 1: high from an accepted start until done.
REQ-015 Port done, output, 1: one-cycle pulse; result and activeCount are valid from this cycle.
REQ-016 Port result, output, ACC_WIDTH: signed neuron output, held until the next accepted start.
REQ-017 Port activeCount, output, INDEX_WIDTH+1: number of indices accumulated.

Function
REQ-018 FSM states SHALL be IDLE, REQ, WAIT, ACC and FIN.
REQ-019 IDLE with start high: acc <= bias, count <= 0, busy <= 1, go to REQ.
REQ-020 A start pulse outside IDLE SHALL be ignored.
REQ-021 REQ with queueEmpty=0: weightAddr <= indexIn, dequeue=1 for this cycle only, go to WAIT.
REQ-022 REQ with queueEmpty=1: go to FIN, dequeue=0.
REQ-023 WAIT: no action; weightData becomes valid; go to ACC.
REQ-024 ACC: acc <= sat(acc + sign-extended weightData), count += 1, go to REQ.
REQ-025 Each index SHALL cost exactly 3 cycles (REQ, WAIT, ACC).
REQ-026 Addition SHALL saturate to the signed ACC_WIDTH bounds: +524287 / -524288 at default width.
REQ-027 FIN: result <= activation(acc), activeCount <= count, done=1 for one cycle, busy <= 0, go to IDLE.
REQ-028 Latency from start to done SHALL be 3N+2 cycles for N queued indices; an empty queue gives done 2 cycles after start.
REQ-029 dequeue SHALL never assert while queueEmpty=1 or outside REQ.
REQ-030 weightAddr SHALL hold its value outside REQ.

Reset
REQ-031 On reset: state=IDLE; dequeue, busy and done = 0; weightAddr, result, activeCount and acc = 0.
REQ-032 Reset SHALL take priority over start and over any in-flight evaluation; the partial sum SHALL be discarded and done SHALL NOT pulse.

Configuration
REQ-033 Macro RELU_EN defined: activation(x) = x when x>0, else 0.
REQ-034 Macro RELU_EN undefined: activation(x) = x, with the signed value passed through unchanged.

Verification
REQ-035 bias=5; queue {2,4,7} with weights {+10,-3,+20} -> three dequeue pulses, done at cycle 11, result=32, activeCount=3.
REQ-036 Queue empty at start, bias=-7 -> no dequeue, done 2 cycles after start; result=-7, or result=0 with RELU_EN.
REQ-037 bias=524280; two indices with weight +127 each -> result=524287 (saturated), activeCount=2.
REQ-038 Second start pulse while busy -> ignored; exactly one done pulse, result unaffected.
REQ-039 Reset asserted in WAIT of the second index -> next cycle: state IDLE, all outputs 0, no done; a fresh start with queue {0} and weight +1 and bias 0 -> result=1.
REQ-040 Sum -50 (bias -50, empty queue), built with and without RELU_EN -> result 0 and -50 respectively.

Source files
------------

// File: rtl/sparse_neuron_accumulator.sv
// sparse_neuron_accumulator
// Accumulates signed weights for every index popped from an upstream
// set-pixel queue, starting from a signed bias, with saturating addition.
// Weights come from a synchronous ROM addressed by weightAddr.
// Optional feature macro: RELU_EN (clamps non-positive results to zero).
module sparse_neuron_accumulator #(
    parameter int INDEX_WIDTH  = 10,
    parameter int WEIGHT_WIDTH = 8,
    parameter int ACC_WIDTH    = 20
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ACC_WIDTH-1:0]   bias,
    input  logic [INDEX_WIDTH-1:0] indexIn,
    input  logic                   queueEmpty,
    output logic                   dequeue,
    output logic [INDEX_WIDTH-1:0] weightAddr,
    input  logic [WEIGHT_WIDTH-1:0] weightData,
    output logic                   busy,
    output logic                   done,
    output logic [ACC_WIDTH-1:0]   result,
    output logic [INDEX_WIDTH:0]   activeCount
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        ACC,
        FIN
    } state_t;

    localparam logic [INDEX_WIDTH:0] CNT_ONE = {{INDEX_WIDTH{1'b0}}, 1'b1};
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    state_t                 state;
    state_t                 next_state;
    logic [ACC_WIDTH-1:0]   acc;
    logic [INDEX_WIDTH:0]   count;
    logic [ACC_WIDTH:0]     sum_wide;
    logic [ACC_WIDTH-1:0]   acc_sat;
    logic [ACC_WIDTH-1:0]   act;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and the single-cycle strobes (dequeue, done).
    always_comb begin
        next_state = state;
        dequeue    = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = REQ;
                end
            end
            REQ: begin
                if (queueEmpty) begin
                    next_state = FIN;
                end else begin
                    dequeue    = 1'b1;
                    next_state = WAIT;
                end
            end
            WAIT: begin
                next_state = ACC;
            end
            ACC: begin
                next_state = REQ;
            end
            FIN: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Saturating add of the sign-extended weight onto the accumulator.
    always_comb begin
        sum_wide = {acc[ACC_WIDTH-1], acc}
                 + {{(ACC_WIDTH+1-WEIGHT_WIDTH){weightData[WEIGHT_WIDTH-1]}}, weightData};
        if (sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1]) begin
            acc_sat = sum_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end else begin
            acc_sat = sum_wide[ACC_WIDTH-1:0];
        end
    end

    // Output activation applied to the final accumulator value.
    always_comb begin
`ifdef RELU_EN
        act = (!acc[ACC_WIDTH-1] && (acc != '0)) ? acc : '0;
`else
        act = acc;
`endif
    end

    // Datapath registers.
    // result/activeCount are captured on the REQ->FIN transition (acc is
    // already final there) so they are valid in the same cycle done pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc         <= '0;
            count       <= '0;
            busy        <= 1'b0;
            weightAddr  <= '0;
            result      <= '0;
            activeCount <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= bias;
                        count <= '0;
                        busy  <= 1'b1;
                    end
                end
                REQ: begin
                    if (!queueEmpty) begin
                        weightAddr <= indexIn;
                    end else begin
                        result      <= act;
                        activeCount <= count;
                    end
                end
                ACC: begin
                    acc   <= acc_sat;
                    count <= count + CNT_ONE;
                end
                FIN: begin
                    busy <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sparse_neuron_accumulator.sv
// tb_sparse_neuron_accumulator
// Directed test of sparse_neuron_accumulator with a queue model and a
// synchronous weight ROM model. Build with +define+RELU_EN to test the
// activation variant; expectations follow the same macro.
`timescale 1ns/1ps
module tb_sparse_neuron_accumulator;

`ifdef RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [19:0] bias;
    logic [9:0]  indexIn;
    logic        queueEmpty;
    logic        dequeue;
    logic [9:0]  weightAddr;
    logic [7:0]  weightData;
    logic        busy;
    logic        done;
    logic [19:0] result;
    logic [10:0] activeCount;

    logic [7:0]  rom  [0:1023];
    logic [9:0]  qarr [0:63];
    int          pops    = 0;
    int          qend    = 0;
    int          donecnt = 0;
    int          viol    = 0;
    int          n_checks = 0;
    int          n_fail   = 0;

    sparse_neuron_accumulator #(
        .INDEX_WIDTH (10),
        .WEIGHT_WIDTH(8),
        .ACC_WIDTH   (20)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .bias       (bias),
        .indexIn    (indexIn),
        .queueEmpty (queueEmpty),
        .dequeue    (dequeue),
        .weightAddr (weightAddr),
        .weightData (weightData),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .activeCount(activeCount)
    );

    always #5 clk = ~clk;

    assign indexIn    = qarr[pops % 64];
    assign queueEmpty = (pops >= qend);

    // Synchronous ROM: data valid one cycle after the address.
    always @(posedge clk) weightData <= rom[weightAddr];

    // Queue pops and done-pulse counting.
    always @(posedge clk) begin
        if (dequeue) pops <= pops + 1;
        if (done) donecnt <= donecnt + 1;
    end

    // dequeue must never fire against an empty queue.
    always @(negedge clk) begin
        if (dequeue && queueEmpty) viol <= viol + 1;
    end

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic load_q(input int n, input logic [9:0] i0, input logic [9:0] i1,
                          input logic [9:0] i2);
        qarr[(pops + 0) % 64] = i0;
        qarr[(pops + 1) % 64] = i1;
        qarr[(pops + 2) % 64] = i2;
        qend = pops + n;
    endtask

    // Pulses start for one cycle; returns at the negedge of cycle 1.
    task automatic do_start(input logic [19:0] b);
        @(negedge clk);
        bias  = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_case(input string tag, input logic [19:0] b, input int n,
                            input logic [9:0] i0, input logic [9:0] i1,
                            input logic [9:0] i2, input longint exp_res);
        int p0, d0, lat;
        load_q(n, i0, i1, i2);
        p0 = pops;
        d0 = donecnt;
        do_start(b);
        lat = 1;
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check_eq({tag, "_latency"}, lat, 3 * n + 2);
        check_eq({tag, "_result"}, $signed(result), exp_res);
        check_eq({tag, "_count"}, activeCount, n);
        check_eq({tag, "_busy_at_done"}, busy, 1);
        check_eq({tag, "_dequeues"}, pops - p0, n);
        @(negedge clk);
        check_eq({tag, "_done_len"}, done, 0);
        check_eq({tag, "_busy_after"}, busy, 0);
        check_eq({tag, "_done_pulses"}, donecnt - d0, 1);
    endtask

    initial begin
        int d0, lat;
        for (int i = 0; i < 1024; i++) rom[i] = 8'd0;
        for (int i = 0; i < 64; i++) qarr[i] = 10'd0;
        rom[2]   = 8'd10;
        rom[4]   = -8'sd3;
        rom[7]   = 8'd20;
        rom[100] = 8'd127;
        rom[101] = 8'd127;
        rom[102] = -8'sd128;
        rom[0]   = 8'd1;

        reset = 1'b1;
        start = 1'b0;
        bias  = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_dequeue", dequeue, 0);
        check_eq("rst_addr", weightAddr, 0);
        check_eq("rst_result", result, 0);
        check_eq("rst_count", activeCount, 0);

        run_case("basic", 20'sd5, 3, 10'd2, 10'd4, 10'd7, 32);
        check_eq("addr_hold", weightAddr, 7);

        run_case("empty", -20'sd7, 0, 10'd0, 10'd0, 10'd0, RELU ? 0 : -7);

        run_case("sat_pos", 20'sd524280, 2, 10'd100, 10'd101, 10'd0, 524287);

        run_case("sat_neg", -20'sd524283, 1, 10'd102, 10'd0, 10'd0, RELU ? 0 : -524288);

        // Second start while busy must be ignored.
        load_q(2, 10'd2, 10'd4, 10'd0);
        d0 = donecnt;
        do_start(20'sd0);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        bias  = 20'sd1000;
        @(negedge clk);
        start = 1'b0;
        lat = 4;
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check_eq("restart_latency", lat, 8);
        check_eq("restart_result", $signed(result), 7);
        check_eq("restart_count", activeCount, 2);
        repeat (5) @(negedge clk);
        check_eq("restart_done_pulses", donecnt - d0, 1);

        // Reset during WAIT of the second index.
        load_q(2, 10'd2, 10'd4, 10'd0);
        d0 = donecnt;
        do_start(20'sd0);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_done", done, 0);
        check_eq("midrst_dequeue", dequeue, 0);
        check_eq("midrst_addr", weightAddr, 0);
        check_eq("midrst_result", result, 0);
        check_eq("midrst_count", activeCount, 0);
        repeat (4) @(negedge clk);
        check_eq("midrst_no_done", donecnt - d0, 0);
        run_case("fresh", 20'sd0, 1, 10'd0, 10'd0, 10'd0, 1);

        run_case("neg50", -20'sd50, 0, 10'd0, 10'd0, 10'd0, RELU ? 0 : -50);

        check_eq("deq_while_empty", viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
